// File: rtl/d_kes_elp_out_buffer_pkg.sv
// Shared parameters and helpers for the KES error-locator output buffer.
package d_kes_elp_out_buffer_pkg;

  localparam int DEF_GF_ORDER = 12;
  localparam int DEF_T        = 14;
  localparam int DEG_W        = 4;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic logic [1:0] count_next(input logic [1:0] count, input fifo_op_e op);
    case (op)
      OP_PUSH: count_next = count + 2'd1;
      OP_POP:  count_next = count - 2'd1;
      default: count_next = count;
    endcase
  endfunction

endpackage

// File: rtl/d_KES_ELP_degree_enc.sv
// Priority encoder: index of the highest set non-zero flag, 0 when none is set.
module d_KES_ELP_degree_enc
  import d_kes_elp_out_buffer_pkg::*;
#(
  parameter int T = DEF_T
) (
  input  logic [T:0]       i_deg_chk,
  output logic [DEG_W-1:0] o_degree
);

  always_comb begin
    o_degree = '0;
    for (int i = 0; i <= T; i++) begin
      if (i_deg_chk[i]) o_degree = DEG_W'(i);
    end
  end

endmodule

// File: rtl/d_kes_elp_out_buffer.sv
// Two-entry ping-pong buffer between KES and Chien search.
// Optional zero-error skip (adds o_no_error) under D_KES_ELP_ZERO_ERR_SKIP_EN.
module d_kes_elp_out_buffer
  import d_kes_elp_out_buffer_pkg::*;
#(
  parameter int GF_ORDER = DEF_GF_ORDER,
  parameter int T        = DEF_T
) (
  input  logic                      i_clk,
  input  logic                      i_RESET_KES,
  input  logic                      i_stop_dec,
  input  logic                      i_KES_done,
  input  logic [(T+1)*GF_ORDER-1:0] i_v_2i_X,
  input  logic [T:0]                i_v_2i_X_deg_chk_bit,
  output logic                      o_buf_full,
  output logic                      o_ELP_valid,
  input  logic                      i_ELP_ready,
  output logic [(T+1)*GF_ORDER-1:0] o_ELP,
  output logic [DEG_W-1:0]          o_ELP_degree,
  output logic                      o_ELP_fail,
  output logic                      o_overflow
`ifdef D_KES_ELP_ZERO_ERR_SKIP_EN
  ,
  output logic                      o_no_error
`endif
);

  localparam int ELP_W = (T+1)*GF_ORDER;

  logic             w_flush;
  logic             w_push;
  logic             w_pop;
  logic             w_zero_err;
  logic             w_fail;
  logic [DEG_W-1:0] w_deg;
  fifo_op_e         w_op;

  logic [1:0] r_count;
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic       r_overflow;

  logic [ELP_W-1:0] w_ent_elp  [2];
  logic [DEG_W-1:0] w_ent_deg  [2];
  logic             w_ent_fail [2];

  d_KES_ELP_degree_enc #(.T(T)) u_deg_enc (
    .i_deg_chk (i_v_2i_X_deg_chk_bit),
    .o_degree  (w_deg)
  );

  assign w_flush = i_RESET_KES | i_stop_dec;
  assign w_fail  = ~i_v_2i_X_deg_chk_bit[0];

`ifdef D_KES_ELP_ZERO_ERR_SKIP_EN
  // A zero-error word needs no Chien search, so it bypasses storage entirely.
  assign w_zero_err = (w_deg == '0) && !w_fail;
`else
  assign w_zero_err = 1'b0;
`endif

  assign o_buf_full  = (r_count == 2'd2);
  assign o_ELP_valid = (r_count != 2'd0);
  assign w_push      = i_KES_done & ~w_zero_err & ~o_buf_full;
  assign w_pop       = o_ELP_valid & i_ELP_ready;
  assign w_op        = fifo_op_e'({w_pop, w_push});

  always_ff @(posedge i_clk) begin
    if (w_flush) begin
      r_count    <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_count  <= count_next(r_count, w_op);
      r_wr_ptr <= r_wr_ptr ^ w_push;
      r_rd_ptr <= r_rd_ptr ^ w_pop;
      // Full blocks the push even if the head leaves this same cycle.
      if (i_KES_done && !w_zero_err && o_buf_full) r_overflow <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic [ELP_W-1:0] r_elp;
    logic [DEG_W-1:0] r_deg;
    logic             r_fail;

    always_ff @(posedge i_clk) begin
      if (w_push && (r_wr_ptr == 1'(gi))) begin
        r_elp  <= i_v_2i_X;
        r_deg  <= w_deg;
        r_fail <= w_fail;
      end
    end

    assign w_ent_elp[gi]  = r_elp;
    assign w_ent_deg[gi]  = r_deg;
    assign w_ent_fail[gi] = r_fail;
  end

  // Entry storage is never cleared; gating on valid gives zero outputs after a flush.
  assign o_ELP        = o_ELP_valid ? w_ent_elp[r_rd_ptr]  : '0;
  assign o_ELP_degree = o_ELP_valid ? w_ent_deg[r_rd_ptr]  : '0;
  assign o_ELP_fail   = o_ELP_valid ? w_ent_fail[r_rd_ptr] : 1'b0;
  assign o_overflow   = r_overflow;

`ifdef D_KES_ELP_ZERO_ERR_SKIP_EN
  logic r_no_error;

  always_ff @(posedge i_clk) begin
    if (w_flush) r_no_error <= 1'b0;
    else         r_no_error <= i_KES_done & w_zero_err;
  end

  assign o_no_error = r_no_error;
`endif

endmodule

// File: tb/tb_d_kes_elp_out_buffer.sv
// Randomized bench for d_kes_elp_out_buffer against a queue-based reference model.
module tb_d_kes_elp_out_buffer;

  localparam int GF    = 12;
  localparam int T     = 14;
  localparam int ELP_W = (T+1)*GF;

  typedef struct packed {
    logic [ELP_W-1:0] elp;
    logic [3:0]       deg;
    logic             fail;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_kes;
  logic             stop_dec;
  logic             kes_done;
  logic [ELP_W-1:0] v_in;
  logic [T:0]       chk_in;
  logic             buf_full;
  logic             elp_valid;
  logic             elp_ready;
  logic [ELP_W-1:0] elp_out;
  logic [3:0]       elp_deg;
  logic             elp_fail;
  logic             overflow;
`ifdef D_KES_ELP_ZERO_ERR_SKIP_EN
  logic             no_error;
  bit               m_noerr;
`endif

  ent_t q[$];
  bit   m_ovf;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  d_kes_elp_out_buffer #(.GF_ORDER(GF), .T(T)) dut (
    .i_clk                (clk),
    .i_RESET_KES          (rst_kes),
    .i_stop_dec           (stop_dec),
    .i_KES_done           (kes_done),
    .i_v_2i_X             (v_in),
    .i_v_2i_X_deg_chk_bit (chk_in),
    .o_buf_full           (buf_full),
    .o_ELP_valid          (elp_valid),
    .i_ELP_ready          (elp_ready),
    .o_ELP                (elp_out),
    .o_ELP_degree         (elp_deg),
    .o_ELP_fail           (elp_fail),
    .o_overflow           (overflow)
`ifdef D_KES_ELP_ZERO_ERR_SKIP_EN
    ,
    .o_no_error           (no_error)
`endif
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ELP_W-1:0] rand_elp();
    logic [191:0] t;
    for (int i = 0; i < 6; i++) t[i*32 +: 32] = $urandom();
    return t[ELP_W-1:0];
  endfunction

  // Degree: scan from the top coefficient down, first non-zero flag wins.
  function automatic logic [3:0] ref_degree(input logic [T:0] c);
    for (int i = T; i > 0; i--) if (c[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic check_outputs();
    ent_t h;
    h = (q.size() > 0) ? q[0] : '0;
    check("valid", elp_valid, q.size() > 0);
    check("full", buf_full, q.size() == 2);
    check("ovf", overflow, m_ovf);
    check("elp", elp_out, h.elp);
    check("deg", elp_deg, h.deg);
    check("fail", elp_fail, h.fail);
`ifdef D_KES_ELP_ZERO_ERR_SKIP_EN
    check("no_error", no_error, m_noerr);
`endif
  endtask

  task automatic step(input logic done, input logic [ELP_W-1:0] elp, input logic [T:0] chk,
                      input logic ready, input logic stop, input logic rst);
    ent_t e;
    bit   full, pop, zero;
    kes_done  = done;
    v_in      = elp;
    chk_in    = chk;
    elp_ready = ready;
    stop_dec  = stop;
    rst_kes   = rst;
    e.elp  = elp;
    e.deg  = ref_degree(chk);
    e.fail = !chk[0];
    @(posedge clk);
    if (stop || rst) begin
      q.delete();
      m_ovf = 0;
`ifdef D_KES_ELP_ZERO_ERR_SKIP_EN
      m_noerr = 0;
`endif
    end else begin
      full = (q.size() == 2);
      pop  = (q.size() > 0) && ready;
      zero = 0;
`ifdef D_KES_ELP_ZERO_ERR_SKIP_EN
      zero    = done && (e.deg == 0) && !e.fail;
      m_noerr = zero;
`endif
      if (done && !zero && full) m_ovf = 1;
      if (pop) q.delete(0);
      if (done && !zero && !full) q.push_back(e);
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic ready);
    step(1'b0, '0, '0, ready, 1'b0, 1'b0);
  endtask

  initial begin
    logic [ELP_W-1:0] a, b, c;
    rst_kes = 1'b1; stop_dec = 1'b0; kes_done = 1'b0;
    v_in = '0; chk_in = '0; elp_ready = 1'b0;
    repeat (2) @(posedge clk);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("reset_valid", elp_valid, 1'b0);

    // Degree 2, v_0 = 1
    a = rand_elp();
    a[GF-1:0] = 12'h001;
    step(1'b1, a, 15'h0007, 1'b0, 1'b0, 1'b0);
    check("d2_valid", elp_valid, 1'b1);
    check("d2_deg", elp_deg, 4'd2);
    check("d2_fail", elp_fail, 1'b0);
    idle(1'b1);

    // Fill, overflow, then in-order drain
    a = rand_elp(); b = rand_elp(); c = rand_elp();
    step(1'b1, a, 15'h0003, 1'b0, 1'b0, 1'b0);
    step(1'b1, b, 15'h0011, 1'b0, 1'b0, 1'b0);
    check("fill_full", buf_full, 1'b1);
    step(1'b1, c, 15'h0101, 1'b1, 1'b0, 1'b0);
    check("ovf_set", overflow, 1'b1);
    check("head_b", elp_out, b);
    idle(1'b1);
    check("drained", elp_valid, 1'b0);

    // count == 1 with simultaneous push and pop
    a = rand_elp(); b = rand_elp();
    step(1'b1, a, 15'h0021, 1'b0, 1'b0, 1'b0);
    check("one_head", elp_out, a);
    step(1'b1, b, 15'h0041, 1'b1, 1'b0, 1'b0);
    check("swap_head", elp_out, b);
    check("swap_notfull", buf_full, 1'b0);
    idle(1'b1);

    // Top-degree coefficient only, v_0 = 0
    a = rand_elp();
    a[GF-1:0] = '0;
    step(1'b1, a, 15'h4000, 1'b0, 1'b0, 1'b0);
    check("d14_deg", elp_deg, 4'd14);
    check("d14_fail", elp_fail, 1'b1);

    // Abort while full and valid
    step(1'b1, rand_elp(), 15'h0003, 1'b0, 1'b0, 1'b0);
    step(1'b1, rand_elp(), 15'h0007, 1'b1, 1'b1, 1'b0);
    check("stop_valid", elp_valid, 1'b0);
    check("stop_full", buf_full, 1'b0);
    check("stop_ovf", overflow, 1'b0);
    check("stop_elp", elp_out, '0);

`ifdef D_KES_ELP_ZERO_ERR_SKIP_EN
    step(1'b1, rand_elp(), 15'h0001, 1'b0, 1'b0, 1'b0);
    check("skip_pulse", no_error, 1'b1);
    check("skip_valid", elp_valid, 1'b0);
    idle(1'b0);
    check("skip_end", no_error, 1'b0);
`endif

    for (int n = 0; n < 800; n++) begin
      logic [T:0] ck;
      ck = T'(0) | (T+1)'($urandom());
      if ($urandom_range(0, 4) == 0) ck = (T+1)'(1) << $urandom_range(0, T);
      if ($urandom_range(0, 7) == 0) ck = '0;
      step(($urandom_range(0, 2) == 0), rand_elp(), ck, $urandom_range(0, 1) == 1,
           $urandom_range(0, 79) == 0, $urandom_range(0, 59) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
